// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: opcode/funct constants, FSM states, stall bus type and signedness helpers for ex_muldiv.
package ex_muldiv_pkg;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;
  localparam logic [2:0] F3_DIV = 3'd4, F3_DIVU = 3'd5, F3_REM = 3'd6, F3_REMU = 3'd7;
  typedef logic [5:0] stall_bus_t;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 == F3_MUL || f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM;
  endfunction
  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
  endfunction
endpackage

// File: rtl/ex_muldiv_iter.sv
// muldiv_iter: 64-bit accumulator doing one radix-2 shift-add multiply or restoring-divide step per enable.
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] nxt
);
  logic [63:0] acc;
  logic [31:0] b_q;
  logic        div_q;
  logic [32:0] sum, diff;
  // multiply: {hi,lo} with lo = multiplier; divide: {remainder, dividend/quotient}
  always_comb begin
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
    diff = acc[63:31] - {1'b0, b_q};
    nxt = div_q ? (diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1}) : {sum, acc[31:1]};
  end
  always_ff @(posedge clk)
    if (!rst) begin
      acc <= '0;
      b_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc <= {32'd0, a};
      b_q <= b;
      div_q <= div;
    end else if (step) acc <= nxt;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide with pipeline stall; define MULDIV_DIV_EN for the divide datapath.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  stall_bus_t      stall_sign,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [6:0]      ex_funct7,
  input  logic [XLEN-1:0] ex_reg1,
  input  logic [XLEN-1:0] ex_reg2,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  output logic [XLEN-1:0] md_result,
  output logic            md_valid,
  output logic [4:0]      md_wd,
  output logic            md_wreg,
  output logic            stallreq_md
);
  md_state_t   state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  f3_q;
  logic        neg, neg_q, stall_c, stall_q, engage, start, special, sa, sb, div, stall_unused;
  logic [31:0] a_mag, b_mag, spec_res, fin;
  logic [63:0] nxt, full;
  assign stall_unused = ^{stall_sign[5], stall_sign[3:0]};
  assign engage = ex_opcode == OPCODE_OP && ex_funct7 == FUNCT7_MULDIV;
  assign start = state == MD_IDLE && engage;
  assign sa = rs1_signed(ex_funct3) && ex_reg1[31];
  assign sb = rs2_signed(ex_funct3) && ex_reg2[31];
  assign a_mag = sa ? -ex_reg1 : ex_reg1;
  assign b_mag = sb ? -ex_reg2 : ex_reg2;
  assign neg = ex_funct3[2] && ex_funct3[1] ? sa : sa ^ sb;
  assign full = neg_q ? -nxt : nxt;
`ifdef MULDIV_DIV_EN
  logic [31:0] dsel;
  assign div = ex_funct3[2];
  assign special = ex_funct3[2] && (ex_reg2 == '0 ||
                   (!ex_funct3[0] && ex_reg1 == 32'h8000_0000 && ex_reg2 == '1));
  assign spec_res = ex_reg2 == '0 ? (ex_funct3[1] ? ex_reg1 : '1) : (ex_funct3[1] ? '0 : 32'h8000_0000);
  assign dsel = f3_q[1] ? nxt[63:32] : nxt[31:0];
  assign fin = f3_q[2] ? (neg_q ? -dsel : dsel) : (f3_q == F3_MUL ? full[31:0] : full[63:32]);
`else
  assign div = 1'b0;
  assign special = ex_funct3[2];
  assign spec_res = '0;
  assign fin = f3_q == F3_MUL ? full[31:0] : full[63:32];
`endif
  muldiv_iter u_iter (
    .clk (clk),
    .rst (rst),
    .load(rdy && start && !special),
    .step(rdy && state == MD_BUSY),
    .div (div),
    .a   (a_mag),
    .b   (b_mag),
    .nxt (nxt)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: state_nxt = engage ? (special ? MD_DONE : MD_BUSY) : MD_IDLE;
      MD_BUSY: state_nxt = cnt == 5'd0 ? MD_DONE : MD_BUSY;
      default: state_nxt = stall_sign[4] ? MD_DONE : MD_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) state <= MD_IDLE;
    else if (rdy) state <= state_nxt;
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      f3_q <= '0;
      neg_q <= 1'b0;
      stall_q <= 1'b0;
      md_result <= '0;
      md_wd <= '0;
      md_wreg <= 1'b0;
    end else if (rdy) begin
      stall_q <= stall_c;
      if (start) begin
        f3_q <= ex_funct3;
        neg_q <= neg;
        md_wd <= ex_wd;
        md_wreg <= ex_wreg;
        cnt <= special ? 5'd0 : 5'd31;
        if (special) md_result <= spec_res;
      end else if (state == MD_BUSY) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd0) md_result <= fin;
      end
    end
  // while frozen the stall request must keep its last value, not follow the live inputs
  assign stall_c = rst && (state == MD_BUSY || start);
  assign stallreq_md = rdy ? stall_c : stall_q;
  assign md_valid = state == MD_DONE;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv; divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, ex_wreg = 1'b0;
  logic [5:0]  stall_sign = '0;
  logic [6:0]  ex_opcode = '0, ex_funct7 = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_reg1 = '0, ex_reg2 = '0, md_result;
  logic [4:0]  ex_wd = '0, md_wd;
  logic        md_valid, md_wreg, stallreq_md;
  int          compared = 0, mismatched = 0, seen;
`ifdef MULDIV_DIV_EN
  localparam int DL = 33;
  localparam logic [31:0] E_DIV = 32'hFFFF_FFFD, E_REM = 32'hFFFF_FFFF, E_DIVU = 32'd14, E_REMU = 32'd2;
  localparam logic [31:0] E_DZ = 32'hFFFF_FFFF, E_OV = 32'h8000_0000, E_RZ = 32'h1234_5678;
`else
  localparam int DL = 1;
  localparam logic [31:0] E_DIV = 0, E_REM = 0, E_DIVU = 0, E_REMU = 0, E_DZ = 0, E_OV = 0, E_RZ = 0;
`endif

  ex_muldiv dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall_sign),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .md_result(md_result), .md_valid(md_valid), .md_wd(md_wd), .md_wreg(md_wreg),
    .stallreq_md(stallreq_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ex_opcode = 7'b0110011; ex_funct7 = 7'b0000001; ex_funct3 = f3;
    ex_reg1 = a; ex_reg2 = b; ex_wd = {2'b0, f3} + 5'd1; ex_wreg = ~f3[0];
  endtask

  // Engage, count cycles to md_valid and stall-high cycles, optionally freeze rdy and hold DONE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int rdy_at, input int hold);
    int n, st;
    @(negedge clk);
    drive_m(f3, a, b);
    #1;
    n = 0; st = 0;
    while (!md_valid && n < 100) begin
      if (stallreq_md) st++;
      @(negedge clk);
      rdy = !(rdy_at >= 0 && n + 1 > rdy_at && n + 1 <= rdy_at + 5);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_stall_cycles"}, st, lat);
    check({tag, "_result"}, md_result, exp);
    check({tag, "_wd"}, {27'd0, md_wd}, {27'd0, {2'b0, f3} + 5'd1});
    check({tag, "_wreg"}, {31'd0, md_wreg}, {31'd0, ~f3[0]});
    check({tag, "_stall_done"}, {31'd0, stallreq_md}, 32'd0);
    if (hold > 0) begin
      stall_sign = 6'b010000;
      for (int k = 1; k <= hold; k++) begin
        @(negedge clk);
        if (k == hold) stall_sign = '0;
        #1;
        check({tag, "_hold_valid"}, {31'd0, md_valid}, 32'd1);
        check({tag, "_hold_result"}, md_result, exp);
        check({tag, "_hold_stall"}, {31'd0, stallreq_md}, 32'd0);
      end
    end
    @(negedge clk);
    ex_opcode = '0; ex_funct7 = '0;
    #1;
    check({tag, "_idle_valid"}, {31'd0, md_valid}, 32'd0);
    check({tag, "_idle_stall"}, {31'd0, stallreq_md}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_m(3'd0, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, md_valid}, 32'd0);
    check("rst_result", md_result, 32'd0);
    check("rst_wd", {27'd0, md_wd}, 32'd0);
    check("rst_wreg", {31'd0, md_wreg}, 32'd0);
    check("rst_stall", {31'd0, stallreq_md}, 32'd0);
    @(negedge clk);
    rst = 1'b1; ex_opcode = '0; ex_funct7 = '0;
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1, 0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, -1, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, E_DIV, DL, -1, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, E_REM, DL, -1, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, E_DIVU, DL, -1, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, E_REMU, DL, -1, 0);
    run_op("div_zero", 3'd4, 32'h1234_5678, 32'd0, E_DZ, 1, -1, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, E_OV, 1, -1, 0);
    run_op("rem_zero", 3'd6, 32'h1234_5678, 32'd0, E_RZ, 1, -1, 0);
    // abort at BUSY cycle 10 with a synchronous reset pulse
    @(negedge clk);
    drive_m(3'd0, 32'd5, 32'd6);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (md_valid) seen++;
    end
    rst = 1'b0;
    #1;
    check("abort_rst_stall", {31'd0, stallreq_md}, 32'd0);
    @(negedge clk);
    rst = 1'b1; ex_opcode = '0; ex_funct7 = '0;
    #1;
    check("abort_idle_stall", {31'd0, stallreq_md}, 32'd0);
    repeat (30) begin
      @(negedge clk);
      #1;
      if (md_valid) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
    run_op("mul_after_abort", 3'd0, 32'd3, 32'd4, 32'h0000_000C, 33, -1, 0);
    run_op("rdy_freeze", 3'd0, 32'd9, 32'd9, 32'd81, 38, 10, 0);
    run_op("done_hold", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'd3, 33, -1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, consuming the instruction fields registered by the ID/EX pipeline register. It recognises OP-opcode instructions with funct7 = 0000001, computes the result over 32 radix-2 iterations, and holds the pipeline meanwhile through a stall request to the control unit. It sits in parallel with the ALU. The EX result mux selects `md_result` when `md_valid` is high.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `rdy` input 1: global ready; while low, all state freezes.
- `stall_sign` input `StallBus`: control-unit stall vector. Bit [4] high means EX/MEM is frozen by a downstream stage.
- `ex_opcode` input 7: instruction opcode from ID/EX.
- `ex_funct3` input 3: operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- `ex_funct7` input 7: must equal 0000001 for this unit to engage.
- `ex_reg1` input 32: rs1 value.
- `ex_reg2` input 32: rs2 value.
- `ex_wd` input 5: destination register address.
- `ex_wreg` input 1: write enable.
- `md_result` output 32: result, valid while `md_valid` is high.
- `md_valid` output 1: result present this cycle.
- `md_wd` output 5: destination address, captured at start.
- `md_wreg` output 1: write enable, captured at start.
- `stallreq_md` output 1: stall request to control. It freezes IF through ID/EX and bubbles EX/MEM.

## Operation
- Engage condition: `ex_opcode` = 0110011 and `ex_funct7` = 0000001.
- FSM states are IDLE, BUSY, and DONE.
- IDLE:
  - When the engage condition holds, capture operands, funct3, `ex_wd`, and `ex_wreg`.
  - `stallreq_md` is combinationally high in this same cycle.
  - Normal case: go to BUSY with iteration counter = 31.
  - Special case: go directly to DONE.
- BUSY:
  - Performs one shift-add (multiply) or shift-subtract restoring step (divide) per cycle.
  - Decrements the counter each cycle.
  - At counter = 0, goes to DONE.
- DONE:
  - `md_valid` = 1, `stallreq_md` = 0, `md_result` is driven.
  - Leaves for IDLE next cycle unless `stall_sign[4]` is high, in which case it stays in DONE holding all outputs.
  - The instruction still on the inputs in DONE never re-triggers the unit.
- Signed handling: iterate on magnitudes, then conditionally negate.
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Product is 64-bit. MUL returns bits [31:0]; the MULH variants return bits [63:32].
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases take 1-cycle latency with no iteration:
  - Divide by zero: quotient = FFFFFFFF, remainder = rs1.
  - Overflow (rs1 = 80000000, rs2 = FFFFFFFF, signed): quotient = 80000000, remainder = 0.
- `rdy` low: FSM, counter, datapath, and outputs all hold. `stallreq_md` keeps its last value.
- Non-engaging instructions leave the unit in IDLE with `md_valid` = 0.

## Timing
- Reset: state IDLE, counter 0, and all outputs 0 (`md_result`, `md_valid`, `md_wd`, `md_wreg`, `stallreq_md`).
- Reset mid-operation aborts to IDLE. The partial result is discarded and no `md_valid` pulse is produced.
- Normal latency:
  - Engage in cycle T.
  - BUSY for cycles T+1..T+32.
  - DONE in cycle T+33.
  - `stallreq_md` is high for T..T+32 (33 cycles).
- Special-case latency: DONE in T+1; `stallreq_md` is high in T only.
- Back-to-back M instructions: the second engages in the first IDLE cycle after DONE.

## Configuration
- `MULDIV_DIV_EN` defined: full RV32M; DIV, DIVU, REM, and REMU are iterative as above.
- `MULDIV_DIV_EN` undefined:
  - The divide datapath and special-case logic are compiled out.
  - funct3[2] = 1 goes IDLE → DONE in 1 cycle with `md_result` = 0 and `md_wreg` passed through.
  - Multiply behaviour is unchanged.

## Structure
- Shared `defines.v` constants:
  - `OPCODE_OP` = 0110011.
  - `FUNCT7_MULDIV` = 0000001.
  - Eight funct3 codes: `F3_MUL` … `F3_REMU`.
  - FSM state encodings: `MD_IDLE`, `MD_BUSY`, `MD_DONE`.
- One sub-module, `muldiv_iter`, holds the 64-bit shift register/accumulator and performs one step per enable. `ex_muldiv` owns the FSM, sign handling, special cases, and stall logic.

## Test plan
- MUL 7 × FFFFFFFD (−3): `md_valid` at T+33, result FFFFFFEB; `stallreq_md` high for exactly 33 cycles.
- MULH 80000000 × 80000000 → 40000000. MULHU FFFFFFFF × FFFFFFFF → FFFFFFFE. MULHSU FFFFFFFF × FFFFFFFF → FFFFFFFF.
- DIV −7 / 2 → FFFFFFFD. REM −7 / 2 → FFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV x / 0 and DIV 80000000 / FFFFFFFF: DONE at T+1 with FFFFFFFF and 80000000 respectively. REM x / 0 → x.
- `rst` low at BUSY cycle 10, then MUL 3 × 4 is issued: no stray `md_valid`; the new result 0000000C appears 33 cycles after engage.
- `rdy` low for 5 cycles mid-BUSY gives DONE at T+38. `stall_sign[4]` high in DONE holds the result for 3 cycles and causes no retrigger.
